host_spi_slave_mc: RTL and testbench

Parametrised successor to the single floppy/user host SPI port pair. One oversampled SPI slave (mode 0) serves NUM_CS chip selects from the host controller: word width and channel count are generic. It adds per-word RX strobes tagged with channel, a buffered TX holding register, and underrun/abort/conflict status. Sits between the host controller pins and the floppy, user and OSD register blocks.

---
 rtl/host_spi_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/host_spi_slave_mc.sv | 173 +++++++++++++++++
 tb/tb_host_spi_slave_mc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/host_spi_pkg.sv
// rtl/host_spi_pkg.sv - shared state type, defaults and chip-select priority encoder for host_spi_slave_mc
package host_spi_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_NUM_CS = 3;
   localparam int MAX_CS     = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT
   } spi_state_t;

   // Lowest set index wins; the vector is active-high "selected".
   function automatic logic [2:0] cs_priority(input logic [MAX_CS-1:0] sel);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = MAX_CS - 1; i >= 0; i--)
         if (sel[i]) idx = 3'(i);
      return idx;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchroniser plus history FF giving level, rise and fall of one input bit
module spi_sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1, s2, hist;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= RESET_VAL;
         s2   <= RESET_VAL;
         hist <= RESET_VAL;
      end else begin
         s1   <= d;
         s2   <= s1;
         hist <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~hist;
   assign fall  = ~s2 & hist;

endmodule

// File: rtl/host_spi_slave_mc.sv
// rtl/host_spi_slave_mc.sv - oversampled mode-0 SPI slave for NUM_CS channels; HOST_SPI_LSB_FIRST_EN selects LSB-first
module host_spi_slave_mc
   import host_spi_pkg::*;
#(
   parameter int                DATA_W  = DEF_DATA_W,
   parameter int                NUM_CS  = DEF_NUM_CS,
   parameter int                CHAN_W  = 2,
   parameter logic [DATA_W-1:0] TX_FILL = '1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   input  logic [NUM_CS-1:0] spi_cs_n,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [DATA_W-1:0] rx_data,
   output logic [CHAN_W-1:0] rx_chan,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_empty,
   output logic              tx_underrun,
   output logic              word_abort,
   output logic              cs_conflict
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic sck_lvl, sck_rise, sck_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic [NUM_CS-1:0] cs_lvl, cs_rise, cs_fall;

   spi_sync_edge #(.RESET_VAL(1'b0)) u_sck (
      .clk(clk), .reset(reset), .d(spi_sck),
      .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));

   spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
      .clk(clk), .reset(reset), .d(spi_mosi),
      .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

   for (genvar g = 0; g < NUM_CS; g++) begin : g_cs
      spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
         .clk(clk), .reset(reset), .d(spi_cs_n[g]),
         .level(cs_lvl[g]), .rise(cs_rise[g]), .fall(cs_fall[g]));
   end

   logic [MAX_CS-1:0] sel;
   logic              any_sel;
   logic [CHAN_W-1:0] win_chan;

   always_comb begin
      sel = '0;
      sel[NUM_CS-1:0] = ~cs_lvl;
   end

   assign any_sel     = |sel;
   assign win_chan    = CHAN_W'(cs_priority(sel));
   assign cs_conflict = (sel & (sel - MAX_CS'(1))) != '0;

   spi_state_t        state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CHAN_W-1:0] chan;
   logic [DATA_W-1:0] rx_shift, rx_next;
   logic [DATA_W-1:0] tx_shift, tx_next;
   logic [DATA_W-1:0] tx_hold;
   logic              word_done, done_d;
   logic              rx_spare;

`ifdef HOST_SPI_LSB_FIRST_EN
   localparam int TX_BIT = 0;
   assign rx_next  = {mosi_lvl, rx_shift[DATA_W-1:1]};
   assign tx_next  = {1'b1, tx_shift[DATA_W-1:1]};
   assign rx_spare = rx_shift[0];
`else
   localparam int TX_BIT = DATA_W - 1;
   assign rx_next  = {rx_shift[DATA_W-2:0], mosi_lvl};
   assign tx_next  = {tx_shift[DATA_W-2:0], 1'b1};
   assign rx_spare = rx_shift[DATA_W-1];
`endif

   logic unused_sync;
   assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall, cs_rise, cs_fall, rx_spare};

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         chan        <= '0;
         rx_shift    <= '0;
         tx_shift    <= TX_FILL;
         tx_hold     <= '0;
         rx_data     <= '0;
         rx_chan     <= '0;
         word_done   <= 1'b0;
         done_d      <= 1'b0;
         rx_valid    <= 1'b0;
         tx_empty    <= 1'b1;
         tx_underrun <= 1'b0;
         word_abort  <= 1'b0;
         spi_miso    <= 1'b1;
         spi_miso_oe <= 1'b0;
      end else begin
         tx_underrun <= 1'b0;
         word_abort  <= 1'b0;
         word_done   <= 1'b0;
         // two extra stages so rx_valid lands 4 clk after the final SCK high is first sampled
         done_d      <= word_done;
         rx_valid    <= done_d;

         if (tx_load) begin
            tx_hold  <= tx_data;
            tx_empty <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               bit_cnt     <= '0;
               spi_miso    <= 1'b1;
               spi_miso_oe <= 1'b0;
               if (any_sel) state <= ST_LOAD;
            end

            ST_LOAD: begin
               chan        <= win_chan;
               spi_miso_oe <= 1'b1;
               if (!tx_empty) begin
                  tx_shift <= tx_hold;
                  spi_miso <= tx_hold[TX_BIT];
                  if (!tx_load) tx_empty <= 1'b1;
               end else begin
                  tx_shift    <= TX_FILL;
                  spi_miso    <= TX_FILL[TX_BIT];
                  tx_underrun <= 1'b1;
               end
               state <= ST_SHIFT;
            end

            ST_SHIFT: begin
               if (!any_sel || win_chan != chan) begin
                  if (bit_cnt != '0) word_abort <= 1'b1;
                  bit_cnt <= '0;
                  if (any_sel) begin
                     state <= ST_LOAD;
                  end else begin
                     state       <= ST_IDLE;
                     spi_miso    <= 1'b1;
                     spi_miso_oe <= 1'b0;
                  end
               end else if (sck_rise) begin
                  if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                     rx_data   <= rx_next;
                     rx_chan   <= chan;
                     word_done <= 1'b1;
                     bit_cnt   <= '0;
                     state     <= ST_LOAD;
                  end else begin
                     rx_shift <= rx_next;
                     bit_cnt  <= bit_cnt + 1'b1;
                  end
               end else if (sck_fall && bit_cnt != '0) begin
                  // a fall at count 0 is the tail of the previous word; the preloaded bit must stay
                  tx_shift <= tx_next;
                  spi_miso <= tx_next[TX_BIT];
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_host_spi_slave_mc.sv
// tb/tb_host_spi_slave_mc.sv - self-checking bench for host_spi_slave_mc (HOST_SPI_LSB_FIRST_EN aware)
module tb_host_spi_slave_mc;

   localparam int DATA_W = 16;
   localparam int NUM_CS = 3;
   localparam int CHAN_W = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              spi_sck = 1'b0;
   logic              spi_mosi = 1'b0;
   logic [NUM_CS-1:0] spi_cs_n = '1;
   logic              spi_miso, spi_miso_oe;
   logic [DATA_W-1:0] rx_data;
   logic [CHAN_W-1:0] rx_chan;
   logic              rx_valid;
   logic [DATA_W-1:0] tx_data = '0;
   logic              tx_load = 1'b0;
   logic              tx_empty, tx_underrun, word_abort, cs_conflict;

   always #5 clk = ~clk;

   host_spi_slave_mc #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .CHAN_W(CHAN_W)) dut (
      .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
      .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .rx_data(rx_data), .rx_chan(rx_chan), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
      .tx_underrun(tx_underrun), .word_abort(word_abort), .cs_conflict(cs_conflict));

   typedef struct {
      logic [15:0] data;
      logic [1:0]  chan;
      int          due;
   } sb_t;

   typedef struct {
      logic [2:0]  cs_n;
      logic        load;
      logic [15:0] hold;
      logic [15:0] mosi;
      logic [1:0]  chan;
      logic        conflict;
   } vec_t;

   sb_t  sb_q[$];
   sb_t  mon_e;
   vec_t vecs[5];

   int n_vec = 0, n_err = 0, cyc = 0;
   int n_underrun = 0, n_abort = 0, n_valid = 0, n_push = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!reset) begin
         if (tx_underrun) n_underrun++;
         if (word_abort) n_abort++;
         if (rx_valid) begin
            n_valid++;
            if (sb_q.size() == 0) begin
               check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(mon_e.data));
               check("rx_chan", 32'(rx_chan), 32'(mon_e.chan));
               check("rx_latency", 32'(cyc), 32'(mon_e.due));
            end
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_hold(input logic [15:0] w);
      tx_data = w;
      tx_load = 1'b1;
      wait_clk(1);
      tx_load = 1'b0;
   endtask

   // Host side: data set while SCK low, 8 clk per SCK phase.
   task automatic spi_bits(input logic [15:0] w, input int nbits, input logic push,
                           input logic [1:0] chan, output logic [15:0] miso_w);
      miso_w = '0;
      for (int i = 0; i < nbits; i++) begin
`ifdef HOST_SPI_LSB_FIRST_EN
         spi_mosi = w[i];
`else
         spi_mosi = w[15-i];
`endif
         wait_clk(8);
`ifdef HOST_SPI_LSB_FIRST_EN
         miso_w = {spi_miso, miso_w[15:1]};
`else
         miso_w = {miso_w[14:0], spi_miso};
`endif
         if (push && i == nbits - 1) begin
            // first posedge after this drive samples SCK high; valid 4 clk after that
            sb_q.push_back('{data: w, chan: chan, due: cyc + 5});
            n_push++;
         end
         spi_sck = 1'b1;
         wait_clk(8);
         spi_sck = 1'b0;
      end
   endtask

   logic [15:0] mw;
   int u0, a0, v0;

   initial begin
      vecs[0] = '{cs_n: 3'b101, load: 1'b1, hold: 16'hA55A, mosi: 16'h1234, chan: 2'd1, conflict: 1'b0};
      vecs[1] = '{cs_n: 3'b010, load: 1'b1, hold: 16'h0F0F, mosi: 16'hBEEF, chan: 2'd0, conflict: 1'b1};
      vecs[2] = '{cs_n: 3'b011, load: 1'b0, hold: 16'h0000, mosi: 16'h00FF, chan: 2'd2, conflict: 1'b0};
      vecs[3] = '{cs_n: 3'b110, load: 1'b1, hold: 16'h8001, mosi: 16'h0001, chan: 2'd0, conflict: 1'b0};
      vecs[4] = '{cs_n: 3'b101, load: 1'b1, hold: 16'h0000, mosi: 16'hFFFF, chan: 2'd1, conflict: 1'b0};

      wait_clk(4);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_tx_empty", 32'(tx_empty), 32'd1);
      check("rst_miso", 32'(spi_miso), 32'd1);
      check("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      reset = 1'b0;
      wait_clk(4);

      foreach (vecs[k]) begin
         if (vecs[k].load) load_hold(vecs[k].hold);
         wait_clk(1);
         check("tx_empty_before", 32'(tx_empty), 32'(!vecs[k].load));
         u0 = n_underrun;
         spi_cs_n = vecs[k].cs_n;
         wait_clk(4);
         check("cs_conflict", 32'(cs_conflict), 32'(vecs[k].conflict));
         spi_bits(vecs[k].mosi, 16, 1'b1, vecs[k].chan, mw);
         check("miso_word", 32'(mw), 32'(vecs[k].load ? vecs[k].hold : 16'hFFFF));
         // plus one: the post-word preload with CS still low finds the register empty
         check("underrun_cnt", 32'(n_underrun - u0), 32'(vecs[k].load ? 1 : 2));
         spi_cs_n = '1;
         wait_clk(12);
         check("tx_empty_after", 32'(tx_empty), 32'd1);
         check("miso_oe_idle", 32'(spi_miso_oe), 32'd0);
      end

      // three back-to-back words on cs[0], only the first preloaded
      load_hold(16'h1111);
      u0 = n_underrun;
      v0 = n_valid;
      spi_cs_n = 3'b110;
      wait_clk(4);
      spi_bits(16'hAAAA, 16, 1'b1, 2'd0, mw);
      check("b2b_miso0", 32'(mw), 32'h1111);
      spi_bits(16'h5555, 16, 1'b1, 2'd0, mw);
      check("b2b_miso1", 32'(mw), 32'hFFFF);
      spi_bits(16'hC3C3, 16, 1'b1, 2'd0, mw);
      check("b2b_miso2", 32'(mw), 32'hFFFF);
      spi_cs_n = '1;
      wait_clk(12);
      check("b2b_underrun", 32'(n_underrun - u0), 32'd3);
      check("b2b_valid", 32'(n_valid - v0), 32'd3);

      // CS released after 9 bits, then a clean word on the same channel
      a0 = n_abort;
      v0 = n_valid;
      spi_cs_n = 3'b011;
      wait_clk(4);
      spi_bits(16'hF0F0, 9, 1'b0, 2'd2, mw);
      spi_cs_n = '1;
      wait_clk(12);
      check("abort_pulse", 32'(n_abort - a0), 32'd1);
      check("abort_no_valid", 32'(n_valid - v0), 32'd0);
      spi_cs_n = 3'b011;
      wait_clk(4);
      spi_bits(16'h00FF, 16, 1'b1, 2'd2, mw);
      spi_cs_n = '1;
      wait_clk(12);
      check("after_abort_valid", 32'(n_valid - v0), 32'd1);

      // reset mid-word
      load_hold(16'h7777);
      spi_cs_n = 3'b101;
      wait_clk(4);
      spi_bits(16'h1234, 7, 1'b0, 2'd1, mw);
      reset = 1'b1;
      wait_clk(1);
      check("mid_rst_rx_data", 32'(rx_data), 32'd0);
      check("mid_rst_rx_chan", 32'(rx_chan), 32'd0);
      check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
      check("mid_rst_tx_empty", 32'(tx_empty), 32'd1);
      check("mid_rst_underrun", 32'(tx_underrun), 32'd0);
      check("mid_rst_abort", 32'(word_abort), 32'd0);
      check("mid_rst_miso", 32'(spi_miso), 32'd1);
      check("mid_rst_miso_oe", 32'(spi_miso_oe), 32'd0);
      reset = 1'b0;
      spi_cs_n = '1;
      wait_clk(12);
      load_hold(16'h5A5A);
      spi_cs_n = 3'b101;
      wait_clk(4);
      spi_bits(16'h9C3E, 16, 1'b1, 2'd1, mw);
      check("post_rst_miso", 32'(mw), 32'h5A5A);
      spi_cs_n = '1;
      wait_clk(20);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("valid_total", 32'(n_valid), 32'(n_push));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
